ones_mod_detector: RTL
======================

Name: ones_mod_detector

Overview:
- Multi-channel serial-bit classifier, the parametrised successor of the single-lane even-ones Mealy detector.
- Each lane counts the 1-bits received on its serial input modulo MOD.
- Each lane flags when that count equals TARGET.
- Output timing is selectable between Mealy (combinational, includes the current bit) and Moore (registered state only).
- Sits behind serial front-ends as a parity, frame-phase or every-Nth-one indicator.

Parameters:
- CH, 1, number of independent lanes.
- MOD, 2, modulus of the ones count; legal range 2..256.
- TARGET, 0, count value that asserts z; must be less than MOD (elaboration-time assertion).
- MODE, MEALY, output timing: MEALY or MOORE (enum from package).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  sample enable; w is consumed only when en=1.
- clr  in  1  synchronous clear of all lane counters.
- w  in  CH  serial data bit per lane.
- z  out  CH  per-lane match flag.
- count  out  CH*CW  per-lane current count, lane i at bits [i*CW +: CW], where CW = max(1, clog2(MOD)).
- wrap  out  CH  per-lane one-cycle registered pulse, set when the lane's count wrapped MOD-1 -> 0 on the previous edge.

Behaviour:
- Reset (async, rst=1): all counters 0, all wrap bits 0.
  - Moore: z = (0 == TARGET) per lane while rst is held.
  - Mealy: z follows the combinational rule below with count=0.
- State per lane: count in 0..MOD-1. These MOD states are the FSM; MOD=2 reproduces the even/odd-ones machine.
- Next state at each rising clk, evaluated per lane, in priority order:
  1. clr=1: count <- 0, wrap <- 0. clr overrides en and w.
  2. en=1 and w=1: count <- (count == MOD-1) ? 0 : count+1; wrap <- (count == MOD-1).
  3. Otherwise: count holds, wrap <- 0.
- Wrap is explicit compare-to-MOD-1. No reliance on power-of-two overflow; non-power-of-two MOD must work.
- Mealy output:
  - z = (nxt == TARGET), where nxt = count+1 mod MOD if en and w are both 1, else nxt = count.
  - Purely combinational from count, en, w. clr does not affect z in the current cycle.
  - Zero latency: z reflects the bit on w in the same cycle.
- Moore output:
  - z = (count == TARGET), decoded from state only, glitch-free relative to w.
  - Latency: one cycle after the qualifying bit.
- count output is the registered state, identical in both modes.
- Lanes are fully independent. Shared en and clr apply to all lanes simultaneously.
- Reset asserted mid-stream: counts drop to 0 immediately. After release, the first edge behaves as from reset.
- rst deassertion is assumed synchronised externally. No X on any output after reset for any w value.

Decomposition:
- Package ones_mod_pkg: typedef enum {MEALY, MOORE} det_mode_e; function cw_f(MOD) returning max(1, clog2(MOD)).
- Sub-module ones_mod_lane:
  - One counter plus wrap register plus z decode, with the same parameters minus CH.
  - Instantiated CH times in a generate loop.
  - Top level holds only the fan-out and count packing.

Test Plan:
- CH=1, MOD=2, TARGET=0, MEALY, en=1, w stream 1,0,1,1 -> z = 0,0,1,0; count after each edge = 1,1,0,1; wrap pulses in the cycle after the 3rd bit.
- Same stream with MODE=MOORE -> z = 1,0,0,1 (state before each bit); after the last edge z=0.
- MOD=5, TARGET=3, MOORE, five consecutive w=1 -> count 1,2,3,4,0; z=1 only while count=3; wrap=1 one cycle after the 4->0 transition.
- CH=4, lane pattern w=4'b1010 held 3 cycles, MOD=3, TARGET=2, MEALY -> lanes 1 and 3 count 1,2,0; lanes 0 and 2 stay 0; z[3:0] = 4'b1010 during the 2nd bit, then 4'b0000 during the 3rd bit.
- clr=1 together with en=1, w=all ones, count=2 -> next count 0, wrap 0; en=0 with w=1 -> count holds, Mealy z = (count == TARGET).
- rst pulsed asynchronously between edges at count=4 (MOD=5) -> count=0 before the next edge; Moore z = (TARGET == 0); counting resumes from 0 after release.

Source files
------------

// File: rtl/ones_mod_pkg.sv
// Shared types and helpers for the ones-modulo detector.
// Holds the output-timing mode and the count-width helper.
package ones_mod_pkg;

    typedef enum logic {
        MEALY = 1'b0,
        MOORE = 1'b1
    } det_mode_e;

    // Count width: enough bits for 0..MOD-1, never less than one.
    function automatic int unsigned cw_f(input int unsigned m);
        int unsigned w;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ones_mod_lane.sv
// One lane: ones counter modulo MOD, wrap pulse and match decode.
// The counter value is the FSM state; MOD=2 is the even/odd machine.
module ones_mod_lane
    import ones_mod_pkg::*;
#(
    parameter int unsigned MOD = 2,
    parameter int unsigned TARGET = 0,
    parameter det_mode_e MODE = MEALY,
    localparam int unsigned CW = cw_f(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          w,
    output logic          z,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(MOD - 1);
    localparam logic [CW-1:0] TGT  = CW'(TARGET);

    if (MOD < 2 || MOD > 256) begin : g_bad_mod
        $error("ones_mod_lane: MOD out of range 2..256");
    end
    if (TARGET >= MOD) begin : g_bad_target
        $error("ones_mod_lane: TARGET must be below MOD");
    end

    logic          step;
    logic          at_last;
    logic [CW-1:0] peek;
    logic [CW-1:0] cnt_nxt;
    logic          wrap_nxt;

    assign step    = en & w;
    assign at_last = (count == LAST);

    // Next state: clear wins, then a qualified one advances with wrap.
    always_comb begin
        peek     = count;
        cnt_nxt  = count;
        wrap_nxt = 1'b0;
        if (step) begin
            peek = at_last ? '0 : count + CW'(1);
        end
        if (clr) begin
            cnt_nxt  = '0;
            wrap_nxt = 1'b0;
        end else if (step) begin
            cnt_nxt  = peek;
            wrap_nxt = at_last;
        end
    end

    // State and wrap pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= cnt_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Match decode: Moore looks at state only, Mealy at the peeked count.
    if (MODE == MOORE) begin : g_moore
        assign z = (count == TGT);
    end else begin : g_mealy
        assign z = (peek == TGT);
    end

endmodule

// File: rtl/ones_mod_detector.sv
// Multi-lane ones-modulo detector top.
// Fans shared controls out to CH lanes and packs their counts.
module ones_mod_detector
    import ones_mod_pkg::*;
#(
    parameter int unsigned CH = 1,
    parameter int unsigned MOD = 2,
    parameter int unsigned TARGET = 0,
    parameter det_mode_e MODE = MEALY,
    localparam int unsigned CW = cw_f(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CH-1:0]    w,
    output logic [CH-1:0]    z,
    output logic [CH*CW-1:0] count,
    output logic [CH-1:0]    wrap
);

    for (genvar i = 0; i < CH; i++) begin : g_lane
        ones_mod_lane #(
            .MOD    (MOD),
            .TARGET (TARGET),
            .MODE   (MODE)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .clr   (clr),
            .w     (w[i]),
            .z     (z[i]),
            .count (count[i*CW +: CW]),
            .wrap  (wrap[i])
        );
    end

endmodule
